// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word fetches to instruction memory and delivers
// instructions to decode through a registered IF/ID boundary with stall and redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        i_req,
    output logic [31:0] i_address,
    input  logic        i_ack,
    input  logic [31:0] i_data_read,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_next
);

    typedef enum logic [1:0] {
        ST_RST     = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] req_addr_q,   req_addr_d;
    logic [31:0] hold_buf_q,   hold_buf_d;
    logic        if_valid_q,   if_valid_d;
    logic [31:0] if_instr_q,   if_instr_d;
    logic [31:0] if_pc_q,      if_pc_d;
    logic [31:0] if_pc_next_q, if_pc_next_d;

    logic [31:0] redirect_tgt_s;
    logic [31:0] addr_inc_s;
    logic [31:0] addr_dec_s;

    assign redirect_tgt_s = {redirect_pc[31:2], 2'b00};
    assign addr_inc_s     = req_addr_q + 32'd4;
    assign addr_dec_s     = req_addr_q - 32'd4;

    // Memory request is a pure decode of state; the address is the live request register.
    assign i_req     = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
    assign i_address = req_addr_q;

    assign if_valid   = if_valid_q;
    assign if_instr   = if_instr_q;
    assign if_pc      = if_pc_q;
    assign if_pc_next = if_pc_next_q;

    // Next-state and datapath selection; redirect outranks stall and ack in every state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_buf_d = hold_buf_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;

        case (state_q)
            ST_RST: begin
                pc_d       = RESET_PC_ALIGNED;
                req_addr_d = RESET_PC_ALIGNED;
                state_d    = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect) begin
                    if_valid_d = 1'b0;
                    if_instr_d = 32'h0000_0000;
                    hold_buf_d = 32'h0000_0000;
                    pc_d       = redirect_tgt_s;
                    if (i_ack) begin
                        req_addr_d = redirect_tgt_s;
                        state_d    = ST_FETCH;
                    end else begin
                        // Request stays outstanding at the old address until it is acked.
                        state_d    = ST_DISCARD;
                    end
                end else if (stall) begin
                    if (i_ack) begin
                        hold_buf_d = i_data_read;
                        req_addr_d = addr_inc_s;
                        pc_d       = addr_inc_s;
                        state_d    = ST_HOLD;
                    end else begin
                        state_d    = ST_FETCH;
                    end
                end else if (i_ack) begin
                    if_valid_d = 1'b1;
                    if_instr_d = i_data_read;
                    if_pc_d    = req_addr_q;
                    req_addr_d = addr_inc_s;
                    pc_d       = addr_inc_s;
                    state_d    = ST_FETCH;
                end else begin
                    if_valid_d = 1'b0;
                    if_instr_d = 32'h0000_0000;
                    state_d    = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    if_valid_d = 1'b0;
                    if_instr_d = 32'h0000_0000;
                    hold_buf_d = 32'h0000_0000;
                    pc_d       = redirect_tgt_s;
                    req_addr_d = redirect_tgt_s;
                    state_d    = ST_FETCH;
                end else if (stall) begin
                    state_d    = ST_HOLD;
                end else begin
                    if_valid_d = 1'b1;
                    if_instr_d = hold_buf_q;
                    if_pc_d    = addr_dec_s;
                    state_d    = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    if_valid_d = 1'b0;
                    if_instr_d = 32'h0000_0000;
                    pc_d       = redirect_tgt_s;
                    if (i_ack) begin
                        req_addr_d = redirect_tgt_s;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d    = ST_DISCARD;
                    end
                end else if (i_ack) begin
                    req_addr_d = pc_q;
                    state_d    = ST_FETCH;
                end else begin
                    state_d    = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase

        if_pc_next_d = if_pc_d + 32'd4;
    end

    // State and IF/ID registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_RST;
            pc_q         <= RESET_PC_ALIGNED;
            req_addr_q   <= RESET_PC_ALIGNED;
            hold_buf_q   <= 32'h0000_0000;
            if_valid_q   <= 1'b0;
            if_instr_q   <= 32'h0000_0000;
            if_pc_q      <= 32'h0000_0000;
            if_pc_next_q <= 32'h0000_0004;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_buf_q   <= hold_buf_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            if_pc_next_q <= if_pc_next_d;
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset (word-aligned).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 i_req  out  1  instruction-memory request; address valid while high.
REQ-005 i_address  out  32  instruction-memory word address.
REQ-006 i_ack  in  1  memory returns i_data_read this cycle; ignored while i_req low.
REQ-007 i_data_read  in  32  fetched instruction word.
REQ-008 stall  in  1  decode stage cannot accept; IF/ID outputs frozen.
REQ-009 redirect  in  1  taken branch/jump; flush and refetch.
REQ-010 redirect_pc  in  32  target address; bits [1:0] forced to 0.
REQ-011 if_valid  out  1  if_instr holds a real instruction.
REQ-012 if_instr  out  32  instruction to decoder; 32'h0 (NOP) whenever if_valid=0.
REQ-013 if_pc  out  32  address of if_instr.
REQ-014 if_pc_next  out  32  if_pc+4 (link value), mod 2^32.

Function
REQ-015 States: RST, FETCH, HOLD, DISCARD; registers pc, req_addr, hold_buf, IF/ID (if_valid, if_instr, if_pc).
REQ-016 RST: i_req=0; next FETCH with pc=req_addr=RESET_PC.
REQ-017 FETCH: i_req=1, i_address=req_addr; req_addr only changes on the cycle i_ack=1 or in a non-outstanding state.
REQ-018 FETCH, i_ack=1, stall=0, redirect=0: IF/ID <= {1, i_data_read, req_addr}; req_addr <= req_addr+4 (wraps 32'hFFFF_FFFC -> 0); stay FETCH; back-to-back one instruction per cycle at single-cycle ack.
REQ-019 FETCH, i_ack=0, stall=0, redirect=0: IF/ID <= {0, 0, if_pc} (bubble); i_req stays high, address unchanged.
REQ-020 FETCH, stall=1, redirect=0: IF/ID unchanged; if i_ack=1, hold_buf <= i_data_read, req_addr+=4, go HOLD.
REQ-021 HOLD: i_req=0; IF/ID frozen while stall=1; on stall=0: IF/ID <= {1, hold_buf, req_addr-4}, go FETCH.
REQ-022 redirect=1 has priority over stall and over any ack: IF/ID <= {0, 0, if_pc}; hold_buf discarded.
REQ-023 redirect in FETCH with i_ack=0: pc <= redirect_pc, go DISCARD; i_address stays req_addr.
REQ-024 redirect in FETCH with i_ack=1, in HOLD, or in DISCARD with i_ack=1: req_addr <= redirect_pc, go FETCH; returned data dropped.
REQ-025 DISCARD: i_req=1 at old req_addr; on i_ack=1 data dropped, req_addr <= pc, go FETCH; further redirect updates pc, stays DISCARD until ack.
REQ-026 No instruction from a pre-redirect address shall appear with if_valid=1 after redirect is sampled.
REQ-027 Each ack yields at most one if_valid=1 cycle (exactly one if not flushed); no duplication, no loss across stall.
REQ-028 Outputs registered; only i_req/i_address derived from state/req_addr.

Reset
REQ-029 While reset_n=0 at a clock edge: state RST, if_valid=0, if_instr=0, if_pc=0, hold_buf=0, req_addr=pc=RESET_PC; i_req=0 the cycle after.
REQ-030 Reset mid-request (FETCH or DISCARD) abandons it; i_ack during RST ignored.
REQ-031 First request issues the cycle after reset_n rises, at RESET_PC.

Verification
REQ-032 Reset then i_ack=1 every cycle, data=addr^32'hA5A5_0000 -> i_address 0,4,8..; if_pc 0,4,8 one cycle later, if_instr matches, if_pc_next=if_pc+4.
REQ-033 i_ack delayed 3 cycles on addr 8 -> i_address held at 8, three bubbles (if_valid=0, if_instr=0), then if_pc=8 valid.
REQ-034 stall=1 for 4 cycles while addr 12 acks -> IF/ID frozen at 8, i_req=0 in HOLD, stall drop -> if_pc=12 valid once, next request 16.
REQ-035 redirect=1, redirect_pc=32'h0000_0103, during outstanding request at 20 (ack 2 cycles later) -> addr 20 held, data dropped, next request 32'h100, no valid at 20.
REQ-036 redirect and stall and i_ack same cycle -> flush wins, if_valid=0, next i_address=redirect_pc; RESET_PC=32'hFFFF_FFFC -> second fetch address 0.
